// File: rtl/ctrl_pkg.sv
// Shared definitions for the 8-bit computer: opcodes, control-word bit layout, T-state encodings.
package ctrl_pkg;

    typedef logic [15:0] ctrl_word_t;

    typedef enum logic [2:0] {
        StT0 = 3'd0,
        StT1 = 3'd1,
        StT2 = 3'd2,
        StT3 = 3'd3,
        StT4 = 3'd4
    } t_state_e;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int unsigned BIT_HLT = 15;
    localparam int unsigned BIT_MI  = 14;
    localparam int unsigned BIT_RI  = 13;
    localparam int unsigned BIT_RO  = 12;
    localparam int unsigned BIT_IO  = 11;
    localparam int unsigned BIT_II  = 10;
    localparam int unsigned BIT_AI  = 9;
    localparam int unsigned BIT_AO  = 8;
    localparam int unsigned BIT_EO  = 7;
    localparam int unsigned BIT_SU  = 6;
    localparam int unsigned BIT_BI  = 5;
    localparam int unsigned BIT_OI  = 4;
    localparam int unsigned BIT_CE  = 3;
    localparam int unsigned BIT_CO  = 2;
    localparam int unsigned BIT_J   = 1;
    localparam int unsigned BIT_FI  = 0;

    localparam ctrl_word_t CW_HLT = ctrl_word_t'(1) << BIT_HLT;
    localparam ctrl_word_t CW_MI  = ctrl_word_t'(1) << BIT_MI;
    localparam ctrl_word_t CW_RI  = ctrl_word_t'(1) << BIT_RI;
    localparam ctrl_word_t CW_RO  = ctrl_word_t'(1) << BIT_RO;
    localparam ctrl_word_t CW_IO  = ctrl_word_t'(1) << BIT_IO;
    localparam ctrl_word_t CW_II  = ctrl_word_t'(1) << BIT_II;
    localparam ctrl_word_t CW_AI  = ctrl_word_t'(1) << BIT_AI;
    localparam ctrl_word_t CW_AO  = ctrl_word_t'(1) << BIT_AO;
    localparam ctrl_word_t CW_EO  = ctrl_word_t'(1) << BIT_EO;
    localparam ctrl_word_t CW_SU  = ctrl_word_t'(1) << BIT_SU;
    localparam ctrl_word_t CW_BI  = ctrl_word_t'(1) << BIT_BI;
    localparam ctrl_word_t CW_OI  = ctrl_word_t'(1) << BIT_OI;
    localparam ctrl_word_t CW_CE  = ctrl_word_t'(1) << BIT_CE;
    localparam ctrl_word_t CW_CO  = ctrl_word_t'(1) << BIT_CO;
    localparam ctrl_word_t CW_J   = ctrl_word_t'(1) << BIT_J;
    localparam ctrl_word_t CW_FI  = ctrl_word_t'(1) << BIT_FI;

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-side bus: step gate, instruction/flag inputs and the control-word outputs.
interface control_sequencer_if;
    import ctrl_pkg::*;

    logic       step_en;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    ctrl_word_t ctrl;
    logic [2:0] t_state;
    logic       halted;

    modport master (
        output step_en, opcode, carry_flag, zero_flag,
        input  ctrl, t_state, halted
    );

    modport slave (
        input  step_en, opcode, carry_flag, zero_flag,
        output ctrl, t_state, halted
    );
endinterface

// File: rtl/control_sequencer_rom.sv
// Combinational microcode table: (opcode, T-state, flags) -> control word.
module microcode_rom
    import ctrl_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [2:0] t_state_i,
    input  logic       carry_i,
    input  logic       zero_i,
    output ctrl_word_t ctrl_o
);
    always_comb begin
        ctrl_o = '0;
        if (t_state_i == StT0) begin
            ctrl_o = CW_CO | CW_MI;
        end else if (t_state_i == StT1) begin
            ctrl_o = CW_RO | CW_II | CW_CE;
        end else begin
            case (opcode_i)
                OP_NOP: ctrl_o = '0;
                OP_LDA: begin
                    if (t_state_i == StT2)      ctrl_o = CW_IO | CW_MI;
                    else if (t_state_i == StT3) ctrl_o = CW_RO | CW_AI;
                end
                OP_ADD, OP_SUB: begin
                    if (t_state_i == StT2)      ctrl_o = CW_IO | CW_MI;
                    else if (t_state_i == StT3) ctrl_o = CW_RO | CW_BI;
                    else if (t_state_i == StT4) begin
                        ctrl_o = CW_EO | CW_AI | CW_FI | ((opcode_i == OP_SUB) ? CW_SU : '0);
                    end
                end
                OP_STA: begin
                    if (t_state_i == StT2)      ctrl_o = CW_IO | CW_MI;
                    else if (t_state_i == StT3) ctrl_o = CW_AO | CW_RI;
                end
                OP_LDI: if (t_state_i == StT2) ctrl_o = CW_IO | CW_AI;
                OP_JMP: if (t_state_i == StT2) ctrl_o = CW_IO | CW_J;
                OP_JC:  if (t_state_i == StT2 && carry_i) ctrl_o = CW_IO | CW_J;
                OP_JZ:  if (t_state_i == StT2 && zero_i)  ctrl_o = CW_IO | CW_J;
                OP_OUT: if (t_state_i == StT2) ctrl_o = CW_AO | CW_OI;
                OP_HLT: if (t_state_i == StT2) ctrl_o = CW_HLT;
                default: ctrl_o = '0;
            endcase
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute T-state sequencer: steps T0..T4, ends early on empty microsteps, latches HLT.
module control_sequencer
    import ctrl_pkg::*;
#(
    parameter bit EARLY_END = 1'b1
) (
    input logic                clk,
    input logic                rst,
    control_sequencer_if.slave bus_io
);
    t_state_e   t_state_q, t_state_d;
    logic       halted_q, halted_d;
    ctrl_word_t cur_word, next_word, ctrl_out;
    logic [2:0] t_next_idx;

    assign t_next_idx = t_state_q + 3'd1;

    microcode_rom u_rom_cur (
        .opcode_i  (bus_io.opcode),
        .t_state_i (t_state_q),
        .carry_i   (bus_io.carry_flag),
        .zero_i    (bus_io.zero_flag),
        .ctrl_o    (cur_word)
    );

    // Look-ahead at step n+1 decides whether the instruction can end now.
    microcode_rom u_rom_next (
        .opcode_i  (bus_io.opcode),
        .t_state_i (t_next_idx),
        .carry_i   (bus_io.carry_flag),
        .zero_i    (bus_io.zero_flag),
        .ctrl_o    (next_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            t_state_q <= StT0;
            halted_q  <= 1'b0;
        end else begin
            t_state_q <= t_state_d;
            halted_q  <= halted_d;
        end
    end

    always_comb begin
        t_state_d = t_state_q;
        halted_d  = halted_q;
        if (!halted_q && bus_io.step_en) begin
            if (cur_word[BIT_HLT]) begin
                halted_d = 1'b1;
            end else if (t_state_q >= StT4) begin
                t_state_d = StT0;
            end else if (EARLY_END && (t_state_q >= StT2) && (next_word == '0)) begin
                t_state_d = StT0;
            end else begin
                t_state_d = t_state_e'(t_next_idx);
            end
        end
    end

    always_comb begin
        ctrl_out = halted_q ? CW_HLT : cur_word;
    end

    assign bus_io.ctrl    = ctrl_out;
    assign bus_io.t_state = t_state_q;
    assign bus_io.halted  = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: drivers queue expected state per cycle, a negedge monitor pops and compares.
module tb_control_sequencer;
    logic clk = 1'b0;
    logic rst_a, rst_b;

    always #5 clk = ~clk;

    control_sequencer_if ifa ();
    control_sequencer_if ifb ();

    control_sequencer #(.EARLY_END(1'b1)) u_dut_a (.clk(clk), .rst(rst_a), .bus_io(ifa));
    control_sequencer #(.EARLY_END(1'b0)) u_dut_b (.clk(clk), .rst(rst_b), .bus_io(ifb));

    typedef struct {
        bit          d;
        string       name;
        logic [2:0]  t;
        logic        h;
        logic [15:0] c;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input bit d, input string nm, input logic [2:0] t,
                                input logic h, input logic [15:0] c);
        exp_t e;
        e.d = d; e.name = nm; e.t = t; e.h = h; e.c = c;
        sb.push_back(e);
    endtask

    task automatic drive(input bit d, input logic en, input logic [3:0] op,
                         input logic cf, input logic zf);
        if (d) begin
            ifb.step_en = en; ifb.opcode = op; ifb.carry_flag = cf; ifb.zero_flag = zf;
        end else begin
            ifa.step_en = en; ifa.opcode = op; ifa.carry_flag = cf; ifa.zero_flag = zf;
        end
    endtask

    // Runs one instruction from T0; n execute steps with words w2..w4, then back to T0.
    task automatic run_instr(input bit d, input string nm, input logic [3:0] op,
                             input logic cf, input logic zf, input int n,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4);
        logic [15:0] w [3];
        w[0] = w2; w[1] = w3; w[2] = w4;
        drive(d, 1'b1, op, cf, zf);
        tick();
        expect_state(d, {nm, "_T1"}, 3'd1, 1'b0, 16'h1408);
        for (int k = 0; k < n; k++) begin
            tick();
            expect_state(d, $sformatf("%s_T%0d", nm, k + 2), 3'(k + 2), 1'b0, w[k]);
        end
        tick();
        expect_state(d, {nm, "_end"}, 3'd0, 1'b0, 16'h4004);
        drive(d, 1'b0, op, cf, zf);
    endtask

    function automatic int bus_drivers(input logic [15:0] c);
        return int'(c[2]) + int'(c[12]) + int'(c[11]) + int'(c[8]) + int'(c[7]);
    endfunction

    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] ac;
        logic [2:0]  at;
        logic        ah;
        while (sb.size() > 0) begin
            e  = sb.pop_front();
            ac = e.d ? ifb.ctrl : ifa.ctrl;
            at = e.d ? ifb.t_state : ifa.t_state;
            ah = e.d ? ifb.halted : ifa.halted;
            vectors++;
            if ({at, ah, ac} !== {e.t, e.h, e.c}) begin
                miscompares++;
                $display("FAIL %s dut%0d: got t=%0d h=%0b ctrl=%h, want t=%0d h=%0b ctrl=%h",
                         e.name, e.d, at, ah, ac, e.t, e.h, e.c);
            end
        end
        if (!rst_a && !rst_b) begin
            vectors++;
            if ((ifa.ctrl[3] && ifa.ctrl[1]) || (ifb.ctrl[3] && ifb.ctrl[1]) ||
                bus_drivers(ifa.ctrl) > 1 || bus_drivers(ifb.ctrl) > 1) begin
                miscompares++;
                $display("FAIL invariant: got ctrl_a=%h ctrl_b=%h, want no CE&J and <=1 driver",
                         ifa.ctrl, ifb.ctrl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        expect_state(1'b0, "reset_a", 3'd0, 1'b0, 16'h4004);
        expect_state(1'b1, "reset_b", 3'd0, 1'b0, 16'h4004);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Early-end instance.
        run_instr(1'b0, "LDI",   4'h5, 1'b0, 1'b0, 1, 16'h0A00, 16'h0000, 16'h0000);
        run_instr(1'b0, "ADD",   4'h2, 1'b0, 1'b0, 3, 16'h4800, 16'h1020, 16'h0281);
        run_instr(1'b0, "SUB",   4'h3, 1'b0, 1'b0, 3, 16'h4800, 16'h1020, 16'h02C1);
        run_instr(1'b0, "LDA",   4'h1, 1'b0, 1'b0, 2, 16'h4800, 16'h1200, 16'h0000);
        run_instr(1'b0, "STA",   4'h4, 1'b0, 1'b0, 2, 16'h4800, 16'h2100, 16'h0000);
        run_instr(1'b0, "NOP",   4'h0, 1'b1, 1'b1, 1, 16'h0000, 16'h0000, 16'h0000);
        run_instr(1'b0, "OP_B",  4'hB, 1'b1, 1'b1, 1, 16'h0000, 16'h0000, 16'h0000);
        run_instr(1'b0, "JMP",   4'h6, 1'b0, 1'b0, 1, 16'h0802, 16'h0000, 16'h0000);
        run_instr(1'b0, "JC_t",  4'h7, 1'b1, 1'b0, 1, 16'h0802, 16'h0000, 16'h0000);
        run_instr(1'b0, "JC_nt", 4'h7, 1'b0, 1'b1, 1, 16'h0000, 16'h0000, 16'h0000);
        run_instr(1'b0, "JZ_t",  4'h8, 1'b0, 1'b1, 1, 16'h0802, 16'h0000, 16'h0000);
        run_instr(1'b0, "JZ_nt", 4'h8, 1'b1, 1'b0, 1, 16'h0000, 16'h0000, 16'h0000);
        run_instr(1'b0, "OUT",   4'hE, 1'b0, 1'b0, 1, 16'h0110, 16'h0000, 16'h0000);

        // Full-length instance always runs T0..T4.
        run_instr(1'b1, "B_NOP", 4'h0, 1'b0, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);
        run_instr(1'b1, "B_ADD", 4'h2, 1'b0, 1'b0, 3, 16'h4800, 16'h1020, 16'h0281);
        run_instr(1'b1, "B_JC",  4'h7, 1'b0, 1'b0, 3, 16'h0000, 16'h0000, 16'h0000);

        // HLT: halts in T2, ignores step_en and opcode until reset.
        drive(1'b0, 1'b1, 4'hF, 1'b0, 1'b0);
        tick();
        expect_state(1'b0, "HLT_T1", 3'd1, 1'b0, 16'h1408);
        tick();
        expect_state(1'b0, "HLT_T2", 3'd2, 1'b0, 16'h8000);
        tick();
        expect_state(1'b0, "HLT_set", 3'd2, 1'b1, 16'h8000);
        drive(1'b0, 1'b1, 4'h2, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            expect_state(1'b0, "HLT_hold", 3'd2, 1'b1, 16'h8000);
        end
        rst_a = 1'b1;
        tick();
        expect_state(1'b0, "HLT_rst", 3'd0, 1'b0, 16'h4004);
        rst_a = 1'b0;

        // Reset mid-STA dominates step_en, then freeze with step_en=0.
        drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        tick();
        expect_state(1'b0, "STA_T1", 3'd1, 1'b0, 16'h1408);
        tick();
        expect_state(1'b0, "STA_T2", 3'd2, 1'b0, 16'h4800);
        tick();
        expect_state(1'b0, "STA_T3", 3'd3, 1'b0, 16'h2100);
        rst_a = 1'b1;
        tick();
        expect_state(1'b0, "STA_rst", 3'd0, 1'b0, 16'h4004);
        rst_a = 1'b0;
        drive(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_state(1'b0, "freeze_T0", 3'd0, 1'b0, 16'h4004);
        end
        drive(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        tick();
        expect_state(1'b0, "step_T1", 3'd1, 1'b0, 16'h1408);
        drive(1'b0, 1'b0, 4'h4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_state(1'b0, "freeze_T1", 3'd1, 1'b0, 16'h1408);
        end

        @(negedge clk);
        #1;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
